// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared widths, FSM encoding and port indices for dmem_arbiter
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  localparam int P0 = 0;
  localparam int P1 = 1;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - combinational one-hot grant select
// DMEM_ARB_RR_EN selects round-robin on last_gnt instead of fixed priority plus STARVE override.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic       rst,
  input  logic [1:0] req,
`ifdef DMEM_ARB_RR_EN
  input  logic       last_gnt,
`else
  input  arb_state_e state,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
`ifdef DMEM_ARB_RR_EN
      // last_gnt = 1 means port 1 was served most recently
      if (req == 2'b11) begin
        if (last_gnt) gnt[P0] = 1'b1;
        else          gnt[P1] = 1'b1;
      end else begin
        gnt = req;
      end
`else
      if (state == STARVE)  gnt[P1] = req[P1];
      else if (req[P0])     gnt[P0] = 1'b1;
      else                  gnt[P1] = req[P1];
`endif
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a 1-cycle-latency synchronous data memory
// DMEM_ARB_RR_EN builds round-robin arbitration; undefined builds fixed priority with starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] rvalid_q, rvalid_d;

  assign req = {p1_req, p0_req};

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  dmem_arb_grant u_grant (
    .rst      (rst),
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[P0])      last_gnt_d = 1'b0;
    else if (gnt[P1]) last_gnt_d = 1'b1;
  end

  // Reset to "port 1 last" so port 0 wins the first contested cycle
  always_ff @(posedge clk) begin
    if (rst) last_gnt_q <= 1'b1;
    else     last_gnt_q <= last_gnt_d;
  end
`else
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  arb_state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  dmem_arb_grant u_grant (
    .rst   (rst),
    .req   (req),
    .state (state_q),
    .gnt   (gnt)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    if (state_q == STARVE) begin
      state_d = NORMAL;
    end else if (p1_req && !gnt[P1]) begin
      if (wait_cnt_q == WAIT_LAST) state_d = STARVE;
      else                         wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign p0_gnt   = gnt[P0];
  assign p1_gnt   = gnt[P1];
  assign p0_stall = p0_req & ~gnt[P0];

  assign mem_we    = (gnt[P0] & p0_we) | (gnt[P1] & p1_we);
  assign mem_addr  = gnt[P1] ? p1_addr  : p0_addr;
  assign mem_wdata = gnt[P1] ? p1_wdata : p0_wdata;

  assign rvalid_d = {gnt[P1] & ~p1_we, gnt[P0] & ~p0_we};

  always_ff @(posedge clk) begin
    if (rst) rvalid_q <= 2'b00;
    else     rvalid_q <= rvalid_d;
  end

  // Masked by rst so an asserted reset hides a read still in flight
  assign p0_rvalid = rvalid_q[P0] & ~rst;
  assign p1_rvalid = rvalid_q[P1] & ~rst;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule
